altro_rdo_sequencer: RTL
========================

ALTRO_RDO_SEQUENCER -- requirements
Module: altro_rdo_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 12'd4095, max rdoclk cycles waited for req_ack per channel.
REQ-002 SHALL have parameter CHRDO_CODE, default 10'h01A, ALTRO channel-readout command code.
REQ-003 SHALL have port rdoclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rdo_start  input  1  one-cycle readout request (altrordo_cmd).
REQ-006 SHALL have port rdo_abort  input  1  one-cycle abort request (altroabort_cmd).
REQ-007 SHALL have port chmask  input  32  channel enable mask; bit n=1 reads channel n.
REQ-008 SHALL have port fee_addr  input  5  card address placed in command address.
REQ-009 SHALL have port fifo_afull  input  1  readout FIFO almost full; blocks command issue.
REQ-010 SHALL have port req_exec  output  1  one-cycle command strobe to ALTRO bus engine.
REQ-011 SHALL have port req_addr  output  20  {fee_addr[4:0], ch[4:0], CHRDO_CODE[9:0]}.
REQ-012 SHALL have port req_ack  input  1  command completion from ALTRO bus engine.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of sequence (normal or aborted).
REQ-015 SHALL have port aborted  output  1  valid with done; 1 when sequence ended by rdo_abort.
REQ-016 SHALL have port err_timeout  output  1  one-cycle pulse per channel timeout.
REQ-017 SHALL have ports err_clr  input  1 and err_cnt  output  16  timeout error counter and its clear.

Function
REQ-018 SHALL implement states IDLE, SCAN, ISSUE, WAIT_ACK, FINISH.
REQ-019 IDLE: on rdo_start SHALL latch chmask into shadow mask and go to SCAN; rdo_start while busy SHALL be ignored.
REQ-020 SCAN: shadow zero -> FINISH; else SHALL register lowest set bit index as ch, go to ISSUE (1 cycle).
REQ-021 ISSUE: fifo_afull=1 -> hold ISSUE, no req_exec; fifo_afull=0 -> req_exec=1 for exactly one cycle, timer cleared, go WAIT_ACK.
REQ-022 req_addr SHALL be stable from the req_exec cycle until leaving WAIT_ACK.
REQ-023 WAIT_ACK: req_ack=1 SHALL clear shadow bit ch, go SCAN; req_ack in any other state SHALL be ignored.
REQ-024 WAIT_ACK: timer reaching TIMEOUT_CYC without ack SHALL pulse err_timeout, clear shadow bit ch, go SCAN; ack and timeout same cycle counts as ack.
REQ-025 FINISH: done=1, aborted=0 for one cycle, then IDLE.
REQ-026 rdo_abort in any non-IDLE state SHALL go to IDLE next cycle, pulse done with aborted=1, clear shadow; abort in IDLE ignored; abort beats simultaneous ack/timeout (no err_timeout).
REQ-027 Zero chmask at start SHALL yield SCAN->FINISH, done 2 cycles after rdo_start, no req_exec.
REQ-028 err_cnt SHALL increment by 1 per err_timeout, saturate at 16'hFFFF; err_clr sets 0 and wins over simultaneous increment.
REQ-029 Minimum per-channel cost SHALL be 3 cycles (SCAN, ISSUE, ack in first WAIT_ACK cycle).

Reset
REQ-030 reset SHALL force state IDLE, shadow mask 0, ch 0, timer 0, err_cnt 0.
REQ-031 During/after reset SHALL hold req_exec, busy, done, aborted, err_timeout at 0; req_addr = {fee_addr, 5'd0, CHRDO_CODE}.
REQ-032 reset mid-sequence SHALL drop the sequence with no done pulse.

Structure
REQ-033 Shared package altro_rdo_pkg SHALL hold state encoding, CHRDO_CODE default and req_addr field positions.
REQ-034 Lowest-set-bit finder SHALL be sub-module lsb_find32 (32-bit in, 5-bit index + valid out, combinational).

Verification
REQ-035 chmask=32'h0000_0005, ack 2 cycles after each req_exec -> two req_exec, ch 0 then 2, req_addr[14:10]=0 then 2, done with aborted=0.
REQ-036 chmask=32'h8000_0000, fifo_afull high 10 cycles -> req_exec delayed until afull low, req_addr[14:10]=31.
REQ-037 chmask=32'h0000_0003, no ack, TIMEOUT_CYC=16 -> two err_timeout pulses, err_cnt=2, done; then err_clr -> err_cnt=0.
REQ-038 chmask=32'hFFFF_FFFF, rdo_abort during 5th WAIT_ACK -> exactly 5 req_exec, done with aborted=1, busy low next cycle.
REQ-039 chmask=0 -> done 2 cycles after rdo_start, no req_exec; second rdo_start while busy -> ignored.
REQ-040 reset asserted in WAIT_ACK -> all outputs at reset values next cycle, no done.

Source files
------------

// File: rtl/altro_rdo_pkg.sv
// altro_rdo_pkg
//   Shared definitions for the ALTRO channel-readout sequencer:
//   FSM state encoding, default channel-readout command code, and the
//   field layout of the 20-bit ALTRO bus command address.
//   req_addr layout: [19:15] fee_addr, [14:10] channel, [9:0] command code.
package altro_rdo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_FINISH   = 3'd4
    } rdo_state_t;

    localparam logic [9:0] CHRDO_CODE_DEF = 10'h01A;

    localparam int REQ_ADDR_W    = 20;
    localparam int ADDR_CODE_LSB = 0;
    localparam int ADDR_CODE_W   = 10;
    localparam int ADDR_CH_LSB   = 10;
    localparam int ADDR_CH_W     = 5;
    localparam int ADDR_FEE_LSB  = 15;
    localparam int ADDR_FEE_W    = 5;

    function automatic logic [REQ_ADDR_W-1:0] mk_req_addr(
        input logic [ADDR_FEE_W-1:0]  fee,
        input logic [ADDR_CH_W-1:0]   ch,
        input logic [ADDR_CODE_W-1:0] code
    );
        logic [REQ_ADDR_W-1:0] a;
        a = '0;
        a[ADDR_FEE_LSB  +: ADDR_FEE_W]  = fee;
        a[ADDR_CH_LSB   +: ADDR_CH_W]   = ch;
        a[ADDR_CODE_LSB +: ADDR_CODE_W] = code;
        return a;
    endfunction

endpackage

// File: rtl/lsb_find32.sv
// lsb_find32
//   Combinational lowest-set-bit finder.
//   vec : 32-bit input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   vld : 1 when any bit of vec is set
module lsb_find32 (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        vld
);

    // Scan from MSB down so the last hit is the lowest set bit.
    always_comb begin
        idx = '0;
        vld = |vec;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = 5'(i);
        end
    end

endmodule

// File: rtl/altro_rdo_sequencer.sv
// altro_rdo_sequencer
//   Walks the enabled channels of a front-end card lowest-first and issues
//   one ALTRO channel-readout command per channel, waiting for completion
//   (or a timeout) before moving on.
//   Ports:
//     rdoclk, reset         clock, synchronous active-high reset
//     rdo_start, rdo_abort  one-cycle readout / abort requests
//     chmask, fee_addr      channel enable mask, card address
//     fifo_afull            readout FIFO almost full, stalls command issue
//     req_exec, req_addr    command strobe and address to ALTRO bus engine
//     req_ack               command completion from ALTRO bus engine
//     busy, done, aborted   sequence status
//     err_timeout, err_clr, err_cnt   per-channel timeout pulse and counter
module altro_rdo_sequencer
    import altro_rdo_pkg::*;
#(
    parameter logic [11:0] TIMEOUT_CYC = 12'd4095,
    parameter logic [9:0]  CHRDO_CODE  = CHRDO_CODE_DEF
) (
    input  logic        rdoclk,
    input  logic        reset,
    input  logic        rdo_start,
    input  logic        rdo_abort,
    input  logic [31:0] chmask,
    input  logic [4:0]  fee_addr,
    input  logic        fifo_afull,
    output logic        req_exec,
    output logic [19:0] req_addr,
    input  logic        req_ack,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        err_timeout,
    input  logic        err_clr,
    output logic [15:0] err_cnt
);

    rdo_state_t  state;
    logic [31:0] shadow;
    logic [4:0]  ch;
    logic [11:0] timer;
    logic [11:0] timer_nxt;
    logic [4:0]  lsb_idx;
    logic        lsb_vld;

    lsb_find32 u_lsb (
        .vec (shadow),
        .idx (lsb_idx),
        .vld (lsb_vld)
    );

    assign timer_nxt = timer + 12'd1;

    // The strobe fires in the ISSUE cycle itself so an ack in the first
    // WAIT_ACK cycle gives the 3-cycle minimum per channel.
    assign req_exec = (state == ST_ISSUE) && !fifo_afull;

    // ch only changes in SCAN, so the address holds through ISSUE/WAIT_ACK.
    assign req_addr = mk_req_addr(fee_addr, ch, CHRDO_CODE);

    always_ff @(posedge rdoclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            ch          <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;
            err_cnt     <= '0;
        end else begin
            done        <= 1'b0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;

            if (err_clr)
                err_cnt <= '0;
            else if (err_timeout && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;

            // Abort outranks everything, including a same-cycle ack/timeout.
            if (rdo_abort && state != ST_IDLE) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                aborted <= 1'b1;
                shadow  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rdo_start) begin
                            shadow <= chmask;
                            state  <= ST_SCAN;
                            busy   <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (!lsb_vld) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            ch    <= lsb_idx;
                            state <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (!fifo_afull) begin
                            timer <= '0;
                            state <= ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        // timer holds the number of WAIT_ACK cycles already spent.
                        if (req_ack) begin
                            shadow[ch] <= 1'b0;
                            state      <= ST_SCAN;
                        end else if (timer_nxt == TIMEOUT_CYC) begin
                            err_timeout <= 1'b1;
                            shadow[ch]  <= 1'b0;
                            state       <= ST_SCAN;
                        end else begin
                            timer <= timer_nxt;
                        end
                    end
                    ST_FINISH: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
